// File: rtl/common_pkg.sv
// Widths shared across the execution pipeline slice.
package common_pkg;

    localparam int ALL_FLAG_WIDTH  = 8;
    localparam int WAVEFRONT_WIDTH = 6;

endpackage

// File: rtl/ex_pkg.sv
// Execution-stage types: unit index encoding and instruction queue entry layout.
package ex_pkg;

    localparam int UNIT_IDX_WIDTH = 3;

    typedef enum logic [UNIT_IDX_WIDTH-1:0] {
        UNIT_SMEM   = 3'd0,
        UNIT_MBUF   = 3'd1,
        UNIT_MIMG   = 3'd2,
        UNIT_EXPORT = 3'd3,
        UNIT_DS     = 3'd4,
        UNIT_FLAT   = 3'd5,
        UNIT_SCALAR = 3'd6,
        UNIT_VECTOR = 3'd7
    } unit_idx_t;

    // Payload width is a per-instance parameter, so payload is stored beside this entry.
    typedef struct packed {
        unit_idx_t                               unit;
        logic [common_pkg::WAVEFRONT_WIDTH-1:0] wavefront;
    } queue_entry_t;

endpackage

// File: rtl/flag_onehot_encode.sv
// Encodes the decoder unit flags into a unit index and reports whether exactly one flag is set.
module flag_onehot_encode
    import common_pkg::*;
    import ex_pkg::*;
(
    input  logic [ALL_FLAG_WIDTH-1:0] flags,
    output logic [UNIT_IDX_WIDTH-1:0] unit_idx,
    output logic                      onehot
);

    always_comb begin
        unit_idx = '0;
        for (int unsigned i = 0; i < ALL_FLAG_WIDTH; i++) begin
            if (flags[i]) begin
                unit_idx = unit_idx | UNIT_IDX_WIDTH'(i);
            end
        end
        onehot = (flags != '0) && ((flags & (flags - ALL_FLAG_WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/ex1_inst_queue.sv
// In-order instruction queue between decode and the execution units; strict FIFO issue.
module ex1_inst_queue
    import common_pkg::*;
    import ex_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          dec_ex1_valid,
    output logic                          ex1_dec_ready,
    input  logic [ALL_FLAG_WIDTH-1:0]     dec_ex1_all_flags,
    input  logic [WAVEFRONT_WIDTH-1:0]    wavefront_num_in,
    input  logic [PAYLOAD_WIDTH-1:0]      payload_in,
    input  logic                          flush,
    output logic                          issue_valid,
    output logic [2:0]                    issue_unit,
    output logic [WAVEFRONT_WIDTH-1:0]    issue_wavefront,
    output logic [PAYLOAD_WIDTH-1:0]      issue_payload,
    input  logic [ALL_FLAG_WIDTH-1:0]     unit_ready,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          err_flag_onehot
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    queue_entry_t             meta_mem    [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] payload_mem [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [OCC_W-1:0] count;
    logic             err_q;

    logic [UNIT_IDX_WIDTH-1:0] enc_unit;
    logic                      enc_onehot;
    logic                      accept;
    logic                      push;
    logic                      issue_fire;
    queue_entry_t              head_entry;

    flag_onehot_encode u_flag_encode (
        .flags    (dec_ex1_all_flags),
        .unit_idx (enc_unit),
        .onehot   (enc_onehot)
    );

    // Ready depends only on registered occupancy and flush, never on unit_ready.
    assign ex1_dec_ready = (count != DEPTH_OCC) && !flush;
    assign accept        = dec_ex1_valid && ex1_dec_ready;
    assign push          = accept && enc_onehot;

    assign head_entry  = meta_mem[head_ptr];
    assign issue_valid = (count != '0);
    assign issue_fire  = issue_valid && unit_ready[head_entry.unit];

    always_comb begin
        issue_unit      = '0;
        issue_wavefront = '0;
        issue_payload   = '0;
        if (issue_valid) begin
            issue_unit      = head_entry.unit;
            issue_wavefront = head_entry.wavefront;
            issue_payload   = payload_mem[head_ptr];
        end
    end

    assign occupancy       = count;
    assign err_flag_onehot = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= accept && !enc_onehot;
            if (flush) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                end
                if (issue_fire) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                case ({push, issue_fire})
                    2'b10:   count <= count + OCC_W'(1);
                    2'b01:   count <= count - OCC_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is not reset; validity is tracked solely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            meta_mem[tail_ptr]    <= '{unit: unit_idx_t'(enc_unit), wavefront: wavefront_num_in};
            payload_mem[tail_ptr] <= payload_in;
        end
    end

endmodule

// File: tb/tb_ex1_inst_queue.sv
// Randomized and directed checks of ex1_inst_queue against a queue-based reference model.
module tb_ex1_inst_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_ex1_valid;
    logic        ex1_dec_ready;
    logic [7:0]  dec_ex1_all_flags;
    logic [5:0]  wavefront_num_in;
    logic [63:0] payload_in;
    logic        flush;
    logic        issue_valid;
    logic [2:0]  issue_unit;
    logic [5:0]  issue_wavefront;
    logic [63:0] issue_payload;
    logic [7:0]  unit_ready;
    logic [2:0]  occupancy;
    logic        err_flag_onehot;

    ex1_inst_queue #(.DEPTH(4), .PAYLOAD_WIDTH(64)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .dec_ex1_valid     (dec_ex1_valid),
        .ex1_dec_ready     (ex1_dec_ready),
        .dec_ex1_all_flags (dec_ex1_all_flags),
        .wavefront_num_in  (wavefront_num_in),
        .payload_in        (payload_in),
        .flush             (flush),
        .issue_valid       (issue_valid),
        .issue_unit        (issue_unit),
        .issue_wavefront   (issue_wavefront),
        .issue_payload     (issue_payload),
        .unit_ready        (unit_ready),
        .occupancy         (occupancy),
        .err_flag_onehot   (err_flag_onehot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  unit;
        logic [5:0]  wf;
        logic [63:0] pl;
    } ent_t;

    ent_t model_q[$];
    logic err_exp = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] unit_of(input logic [7:0] f);
        for (int i = 0; i < 8; i++) begin
            if (f[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // One cycle: drive at negedge, compare against the model, advance the model at posedge.
    task automatic step(input logic v, input logic [7:0] fl, input logic [5:0] wf,
                        input logic [63:0] pl, input logic fu, input logic [7:0] ur);
        logic exp_ready, transfer, onehot, fire;
        ent_t e;
        @(negedge clk);
        dec_ex1_valid     = v;
        dec_ex1_all_flags = fl;
        wavefront_num_in  = wf;
        payload_in        = pl;
        flush             = fu;
        unit_ready        = ur;
        #1;
        exp_ready = (model_q.size() < 4) && !fu;
        check("ready", 64'(ex1_dec_ready), 64'(exp_ready));
        check("occ", 64'(occupancy), 64'(model_q.size()));
        check("issue_valid", 64'(issue_valid), 64'(model_q.size() != 0));
        check("err", 64'(err_flag_onehot), 64'(err_exp));
        if (model_q.size() != 0) begin
            check("issue_unit", 64'(issue_unit), 64'(model_q[0].unit));
            check("issue_wf", 64'(issue_wavefront), 64'(model_q[0].wf));
            check("issue_pl", issue_payload, model_q[0].pl);
        end else begin
            check("idle_outs", {issue_payload[63:9], issue_unit, issue_wavefront} | 64'(issue_payload[8:0]), 64'd0);
        end
        transfer = v && exp_ready;
        onehot   = ($countones(fl) == 1);
        fire     = (model_q.size() != 0) && ur[model_q[0].unit];
        @(posedge clk);
        err_exp = transfer && !onehot;
        if (fu) begin
            model_q.delete();
        end else begin
            if (fire) void'(model_q.pop_front());
            if (transfer && onehot) begin
                e.unit = unit_of(fl);
                e.wf   = wf;
                e.pl   = pl;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic [7:0] ur);
        step(1'b0, 8'h00, 6'd0, 64'd0, 1'b0, ur);
    endtask

    initial begin
        logic [7:0] fl;
        reset_n           = 1'b0;
        dec_ex1_valid     = 1'b0;
        dec_ex1_all_flags = '0;
        wavefront_num_in  = '0;
        payload_in        = '0;
        flush             = 1'b0;
        unit_ready        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state, then single vector-unit transfer.
        idle(8'h00);
        step(1'b1, 8'h80, 6'd3, 64'hA5, 1'b0, 8'h00);
        #1;
        check("req33_valid", 64'(issue_valid), 64'd1);
        check("req33_unit", 64'(issue_unit), 64'd7);
        check("req33_wf", 64'(issue_wavefront), 64'd3);
        check("req33_pl", issue_payload, 64'hA5);
        idle(8'h80);
        idle(8'h00);

        // Fill with units blocked, fifth offer held until one issue.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h01 << i, 6'(i), 64'(100 + i), 1'b0, 8'h00);
        #1;
        check("full_occ", 64'(occupancy), 64'd4);
        check("full_ready", 64'(ex1_dec_ready), 64'd0);
        step(1'b1, 8'h10, 6'd9, 64'd104, 1'b0, 8'h00);
        step(1'b1, 8'h10, 6'd9, 64'd104, 1'b0, 8'h01);
        step(1'b1, 8'h10, 6'd9, 64'd104, 1'b0, 8'h00);
        #1;
        check("fifth_in", 64'(occupancy), 64'd4);

        // All units ready with continuous offers: order preserved through wrap.
        for (int i = 0; i < 20; i++) step(1'b1, 8'h01 << (i % 8), 6'(i), 64'(200 + i), 1'b0, 8'hFF);
        for (int i = 0; i < 6; i++) idle(8'hFF);
        #1;
        check("drained", 64'(occupancy), 64'd0);

        // Non-onehot flags are consumed and flagged.
        step(1'b1, 8'h00, 6'd1, 64'd1, 1'b0, 8'h00);
        #1;
        check("err_zero", 64'(err_flag_onehot), 64'd1);
        step(1'b1, 8'h03, 6'd1, 64'd2, 1'b0, 8'h00);
        #1;
        check("err_multi", 64'(err_flag_onehot), 64'd1);
        check("err_occ", 64'(occupancy), 64'd0);
        idle(8'h00);

        // Flush with occupancy 3 and a concurrent offer.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h40, 6'(i), 64'(300 + i), 1'b0, 8'h00);
        step(1'b1, 8'h40, 6'd7, 64'd399, 1'b1, 8'hFF);
        #1;
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_valid", 64'(issue_valid), 64'd0);
        idle(8'hFF);

        // Asynchronous reset between edges mid-traffic.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h02, 6'(i), 64'(400 + i), 1'b0, 8'h00);
        #2;
        reset_n       = 1'b0;
        dec_ex1_valid = 1'b0;
        #1;
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_valid", 64'(issue_valid), 64'd0);
        model_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) idle(8'hFF);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, fl, 6'($urandom_range(0, 63)),
                 {$urandom, $urandom}, $urandom_range(0, 40) == 0,
                 ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
